// File: rtl/mac_share_arbiter.sv
// Round-robin front end that time-shares one external pipelined 16x16 signed
// multiplier among NREQ requesters. Each accepted op is tagged, the tag rides a
// fixed-latency pipeline matched to the multiplier, and the product is merged
// with a per-requester accumulator at writeback.
module mac_share_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned ACC_W   = 32
) (
  input  logic               CLK,
  input  logic               RSTN,
  input  logic [NREQ-1:0]    REQ_VALID,
  output logic [NREQ-1:0]    REQ_READY,
  input  logic [16*NREQ-1:0] REQ_A,
  input  logic [16*NREQ-1:0] REQ_B,
  input  logic [2*NREQ-1:0]  REQ_OP,
  output logic [15:0]        MUL_A,
  output logic [15:0]        MUL_B,
  output logic               MUL_EN,
  input  logic [31:0]        MUL_P,
  output logic               RES_VALID,
  output logic [2:0]         RES_ID,
  output logic [ACC_W-1:0]   RES_DATA,
  output logic               BUSY
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  // Tag stage that lines up with MUL_P for its own issue
  localparam int unsigned WB    = MUL_LAT + 1;

  typedef enum logic [1:0] {
    OpMul  = 2'b00,
    OpMac  = 2'b01,
    OpLoad = 2'b10,
    OpClr  = 2'b11
  } op_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] id;
    op_e        op;
  } tag_t;

  logic [PTR_W-1:0] ptr_q;
  logic             found;
  logic [2:0]       grant_id;
  logic [NREQ-1:0]  grant;
  logic [15:0]      sel_a;
  logic [15:0]      sel_b;
  op_e              sel_op;

  tag_t             tag_q [WB+1];
  tag_t             wb_tag;

  logic [ACC_W-1:0] acc_q [NREQ];
  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] acc_cur;
  logic [ACC_W-1:0] wb_data;
  logic             busy_any;

  // Round-robin search: indices above the pointer first, then wrap to 0..ptr
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    grant    = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_op   = OpMul;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && REQ_VALID[i] && (i > 32'(ptr_q))) begin
        found    = 1'b1;
        grant_id = 3'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && REQ_VALID[i] && (i <= 32'(ptr_q))) begin
        found    = 1'b1;
        grant_id = 3'(i);
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (found && (grant_id == 3'(i))) begin
        grant[i] = 1'b1;
        sel_a    = REQ_A[16*i +: 16];
        sel_b    = REQ_B[16*i +: 16];
        sel_op   = op_e'(REQ_OP[2*i +: 2]);
      end
    end
  end

  // READY is forced low while reset is held so nothing looks accepted
  assign REQ_READY = RSTN ? grant : '0;

  // Issue stage: register operands to the multiplier and advance the RR pointer
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ptr_q  <= PTR_W'(NREQ - 1);
      MUL_EN <= 1'b0;
      MUL_A  <= '0;
      MUL_B  <= '0;
    end else if (found) begin
      ptr_q <= grant_id[PTR_W-1:0];
      if (sel_op == OpClr) begin
        // CLR takes a slot but never fires the multiplier
        MUL_EN <= 1'b0;
        MUL_A  <= '0;
        MUL_B  <= '0;
      end else begin
        MUL_EN <= 1'b1;
        MUL_A  <= sel_a;
        MUL_B  <= sel_b;
      end
    end else begin
      MUL_EN <= 1'b0;
    end
  end

  // Tag pipeline: carries {valid, id, op} alongside the multiplier latency
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int unsigned k = 0; k <= WB; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= tag_t'{valid: found, id: grant_id, op: sel_op};
      for (int unsigned k = 1; k <= WB; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // Writeback value: product combined with the addressed accumulator
  always_comb begin
    wb_tag  = tag_q[WB];
    p_ext   = ACC_W'(signed'(MUL_P));
    acc_cur = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (wb_tag.id == 3'(i)) begin
        acc_cur = acc_q[i];
      end
    end
    wb_data = p_ext;
    unique case (wb_tag.op)
      OpMul:   wb_data = p_ext;
      OpMac:   wb_data = acc_cur + p_ext;
      OpLoad:  wb_data = p_ext;
      OpClr:   wb_data = '0;
      default: wb_data = p_ext;
    endcase
  end

  // Writeback registers and accumulators; RES_ID/RES_DATA hold between strobes
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      RES_VALID <= 1'b0;
      RES_ID    <= '0;
      RES_DATA  <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      RES_VALID <= wb_tag.valid;
      if (wb_tag.valid) begin
        RES_ID   <= wb_tag.id;
        RES_DATA <= wb_data;
        for (int unsigned i = 0; i < NREQ; i++) begin
          // MAC, LOAD and CLR all leave the accumulator equal to the result
          if ((wb_tag.id == 3'(i)) && (wb_tag.op != OpMul)) begin
            acc_q[i] <= wb_data;
          end
        end
      end
    end
  end

  // Busy whenever anything is issued, tracked or being reported
  always_comb begin
    busy_any = MUL_EN | RES_VALID;
    for (int unsigned k = 0; k <= WB; k++) begin
      busy_any = busy_any | tag_q[k].valid;
    end
  end

  assign BUSY = busy_any;

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed bench for mac_share_arbiter with a behavioural pipelined multiplier.
module tb_mac_share_arbiter;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 2;
  localparam int ACC_W   = 32;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MAC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  logic               CLK = 1'b0;
  logic               RSTN = 1'b0;
  logic [NREQ-1:0]    REQ_VALID;
  logic [NREQ-1:0]    REQ_READY;
  logic [16*NREQ-1:0] REQ_A;
  logic [16*NREQ-1:0] REQ_B;
  logic [2*NREQ-1:0]  REQ_OP;
  logic [15:0]        MUL_A;
  logic [15:0]        MUL_B;
  logic               MUL_EN;
  logic [31:0]        MUL_P;
  logic               RES_VALID;
  logic [2:0]         RES_ID;
  logic [ACC_W-1:0]   RES_DATA;
  logic               BUSY;

  int n_checks = 0;
  int n_pass   = 0;

  // Step tables for run_seq
  int          s_id  [8];
  logic [15:0] s_a   [8];
  logic [15:0] s_b   [8];
  logic [1:0]  s_op  [8];
  logic [31:0] s_exp [8];
  // Per-requester operands when every requester is valid at once
  logic [15:0] r_a   [NREQ];
  logic [15:0] r_b   [NREQ];
  logic [1:0]  r_op  [NREQ];

  logic [31:0] p_pipe [MUL_LAT+1];

  mac_share_arbiter #(
    .NREQ    (NREQ),
    .MUL_LAT (MUL_LAT),
    .ACC_W   (ACC_W)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_A     (REQ_A),
    .REQ_B     (REQ_B),
    .REQ_OP    (REQ_OP),
    .MUL_A     (MUL_A),
    .MUL_B     (MUL_B),
    .MUL_EN    (MUL_EN),
    .MUL_P     (MUL_P),
    .RES_VALID (RES_VALID),
    .RES_ID    (RES_ID),
    .RES_DATA  (RES_DATA),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    return sa * sb;
  endfunction

  // External multiplier: samples MUL_EN/A/B, product visible MUL_LAT cycles on
  always @(posedge CLK) begin
    p_pipe[0] <= MUL_EN ? mul16(MUL_A, MUL_B) : 32'hDEAD_BEEF;
    for (int k = 1; k <= MUL_LAT; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign MUL_P = p_pipe[MUL_LAT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_reqs();
    REQ_VALID = '0;
    REQ_A     = '0;
    REQ_B     = '0;
    REQ_OP    = '0;
  endtask

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op);
    REQ_VALID[id]      = 1'b1;
    REQ_A[16*id +: 16] = a;
    REQ_B[16*id +: 16] = b;
    REQ_OP[2*id +: 2]  = op;
  endtask

  task automatic set_step(input int k, input int id, input logic [15:0] a,
                          input logic [15:0] b, input logic [1:0] op, input logic [31:0] exp);
    s_id[k]  = id;
    s_a[k]   = a;
    s_b[k]   = b;
    s_op[k]  = op;
    s_exp[k] = exp;
  endtask

  // Drive len steps (one op per cycle) and check grant, issue, result and busy timing
  task automatic run_seq(input int len, input bit all, input string name);
    bit clr;
    for (int n = 0; n < len + 6; n++) begin
      @(negedge CLK);
      clear_reqs();
      if (n < len) begin
        if (all) for (int i = 0; i < NREQ; i++) set_req(i, r_a[i], r_b[i], r_op[i]);
        else set_req(s_id[n], s_a[n], s_b[n], s_op[n]);
      end
      #1;
      if (n < len) check({name, ".ready"}, 32'(REQ_READY), 32'(1) << s_id[n]);
      if (n >= 1 && n <= len) begin
        clr = (s_op[n-1] == OP_CLR);
        check({name, ".mul_en"}, 32'(MUL_EN), clr ? 32'd0 : 32'd1);
        check({name, ".mul_a"}, 32'(MUL_A), clr ? 32'd0 : 32'(s_a[n-1]));
        check({name, ".mul_b"}, 32'(MUL_B), clr ? 32'd0 : 32'(s_b[n-1]));
      end
      if (n >= 5 && n <= len + 4) begin
        check({name, ".res_valid"}, 32'(RES_VALID), 32'd1);
        check({name, ".res_id"}, 32'(RES_ID), 32'(s_id[n-5]));
        check({name, ".res_data"}, RES_DATA, s_exp[n-5]);
      end else begin
        check({name, ".res_idle"}, 32'(RES_VALID), 32'd0);
      end
      check({name, ".busy"}, 32'(BUSY), (n >= 1 && n <= len + 4) ? 32'd1 : 32'd0);
      if (n == len + 5) check({name, ".res_hold"}, RES_DATA, s_exp[len-1]);
    end
  endtask

  initial begin
    bit seen;
    clear_reqs();

    // Reset state, including READY gated off while RSTN is low
    @(negedge CLK);
    REQ_VALID = 4'hF;
    #1;
    check("rst.ready", 32'(REQ_READY), 32'd0);
    check("rst.mul_en", 32'(MUL_EN), 32'd0);
    check("rst.mul_a", 32'(MUL_A), 32'd0);
    check("rst.res_valid", 32'(RES_VALID), 32'd0);
    check("rst.res_data", RES_DATA, 32'd0);
    check("rst.busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    clear_reqs();
    RSTN = 1'b1;

    // Single MUL from req 2: 3 * -4 = -12
    set_step(0, 2, 16'd3, 16'hFFFC, OP_MUL, 32'hFFFF_FFF4);
    run_seq(1, 1'b0, "t1");

    // All valid, pointer left at 2 -> grants 3,0,1,2,...; product = 10*(i+1)
    for (int i = 0; i < NREQ; i++) begin
      r_a[i]  = 16'(i + 1);
      r_b[i]  = 16'd10;
      r_op[i] = OP_MUL;
    end
    set_step(0, 3, 16'd4, 16'd10, OP_MUL, 32'd40);
    set_step(1, 0, 16'd1, 16'd10, OP_MUL, 32'd10);
    set_step(2, 1, 16'd2, 16'd10, OP_MUL, 32'd20);
    set_step(3, 2, 16'd3, 16'd10, OP_MUL, 32'd30);
    set_step(4, 3, 16'd4, 16'd10, OP_MUL, 32'd40);
    set_step(5, 0, 16'd1, 16'd10, OP_MUL, 32'd10);
    set_step(6, 1, 16'd2, 16'd10, OP_MUL, 32'd20);
    set_step(7, 2, 16'd3, 16'd10, OP_MUL, 32'd30);
    run_seq(8, 1'b1, "t2");

    // Back-to-back accumulate on req 1; trailing MAC(0,0) reads acc[1]
    set_step(0, 1, 16'd2, 16'd5, OP_LOAD, 32'd10);
    set_step(1, 1, 16'd3, 16'd3, OP_MAC, 32'd19);
    set_step(2, 1, 16'hFFFF, 16'd7, OP_MAC, 32'd12);
    set_step(3, 1, 16'd0, 16'd0, OP_MAC, 32'd12);
    run_seq(4, 1'b0, "t3");

    // Wrap: each MAC of -32768*-32768 adds 2^30
    set_step(0, 2, 16'd0, 16'd0, OP_CLR, 32'd0);
    for (int k = 1; k < 5; k++) set_step(k, 2, 16'h8000, 16'h8000, OP_MAC, 32'(k) << 30);
    run_seq(5, 1'b0, "t4");

    // CLR on req 0 interleaved with a MAC on req 3
    set_step(0, 0, 16'd7, 16'd7, OP_LOAD, 32'd49);
    set_step(1, 0, 16'd0, 16'd0, OP_CLR, 32'd0);
    set_step(2, 3, 16'd100, 16'hFFFD, OP_MAC, 32'hFFFF_FED4);
    set_step(3, 0, 16'd0, 16'd0, OP_MAC, 32'd0);
    run_seq(4, 1'b0, "t5");

    // Reset with three ops in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      clear_reqs();
      set_req(k + 1, 16'(k + 2), 16'(k + 2), (k == 2) ? OP_MAC : OP_MUL);
    end
    @(negedge CLK);
    clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 16'd0, 16'd0, OP_MAC);
    #1;
    check("t6.busy_pre", 32'(BUSY), 32'd1);
    RSTN = 1'b0;
    #1;
    check("t6.ready", 32'(REQ_READY), 32'd0);
    check("t6.mul_en", 32'(MUL_EN), 32'd0);
    check("t6.mul_a", 32'(MUL_A), 32'd0);
    check("t6.busy", 32'(BUSY), 32'd0);
    check("t6.res_valid", 32'(RES_VALID), 32'd0);
    @(negedge CLK);
    clear_reqs();
    RSTN = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      seen = seen | RES_VALID;
    end
    check("t6.no_stale_res", 32'(seen), 32'd0);

    // After reset: req 0 first, all accumulators read back as 0
    for (int i = 0; i < NREQ; i++) begin
      r_a[i]  = 16'd0;
      r_b[i]  = 16'd0;
      r_op[i] = OP_MAC;
    end
    for (int k = 0; k < 4; k++) set_step(k, k, 16'd0, 16'd0, OP_MAC, 32'd0);
    run_seq(4, 1'b1, "t6r");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
